// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared funct3 codes, LSU state encoding and width helper
package npc_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_ACCESS = 2'd1,
      LSU_DONE   = 2'd2
   } lsu_state_e;

   function automatic logic [3:0] width_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/lsu_ext.sv
// rtl/lsu_ext.sv - load data extract and sign/zero extension by funct3
import npc_pkg::*;

module lsu_ext (
   input  logic [63:0] rdata_i,
   input  logic [2:0]  funct3_i,
   output logic [63:0] rdata_o
);

   always_comb begin
      rdata_o = rdata_i;
      case (funct3_i)
         F3_B:    rdata_o = {{56{rdata_i[7]}},  rdata_i[7:0]};
         F3_H:    rdata_o = {{48{rdata_i[15]}}, rdata_i[15:0]};
         F3_W:    rdata_o = {{32{rdata_i[31]}}, rdata_i[31:0]};
         F3_D:    rdata_o = rdata_i;
         F3_BU:   rdata_o = {56'd0, rdata_i[7:0]};
         F3_HU:   rdata_o = {48'd0, rdata_i[15:0]};
         F3_WU:   rdata_o = {32'd0, rdata_i[31:0]};
         default: rdata_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store control stage between EXU, data memory and WBU
import npc_pkg::*;

module lsu_ctrl #(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [2:0]  in_funct3,
   input  logic [63:0] in_addr,
   input  logic [63:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        mem_en,
   output logic [63:0] mem_r_addr,
   input  logic [63:0] mem_r_data,
   output logic        mem_w_en,
   output logic [63:0] mem_w_addr,
   output logic [63:0] mem_w_data,
   output logic [3:0]  mem_w_width,
   input  logic        mem_skip_ref,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_rdata,
   output logic [4:0]  out_rd,
   output logic        out_rf_wen,
   output logic        out_skip_ref,
   output logic        out_misalign
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   lsu_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [63:0]      addr_q, wdata_q, rdata_q;
   logic [2:0]       funct3_q;
   logic [3:0]       width_q;
   logic [4:0]       rd_q;
   logic             load_q, mem_en_q, w_en_q, in_ready_q, out_valid_q;
   logic             rf_wen_q, skip_q, misalign_q;
   logic             misalign_d;
   logic [63:0]      ext_data;

   // funct3[1:0] encodes the access size for both loads and stores
   always_comb begin
      misalign_d = 1'b0;
      case (in_funct3[1:0])
         2'b01:   misalign_d = in_addr[0];
         2'b10:   misalign_d = |in_addr[1:0];
         2'b11:   misalign_d = |in_addr[2:0];
         default: misalign_d = 1'b0;
      endcase
   end

   lsu_ext u_ext (
      .rdata_i  (mem_r_data),
      .funct3_i (funct3_q),
      .rdata_o  (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LSU_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         funct3_q    <= '0;
         width_q     <= '0;
         rd_q        <= '0;
         load_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         w_en_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         rf_wen_q    <= 1'b0;
         skip_q      <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         case (state_q)
            LSU_IDLE: begin
               if (in_valid && (in_load || in_store)) begin
                  addr_q     <= in_addr;
                  wdata_q    <= in_wdata;
                  funct3_q   <= in_funct3;
                  width_q    <= width_bytes(in_funct3[1:0]);
                  rd_q       <= in_rd;
                  load_q     <= in_load;
                  rdata_q    <= '0;
                  skip_q     <= 1'b0;
                  rf_wen_q   <= 1'b0;
                  in_ready_q <= 1'b0;
                  misalign_q <= misalign_d;
                  cnt_q      <= '0;
                  if (misalign_d) begin
                     out_valid_q <= 1'b1;
                     state_q     <= LSU_DONE;
                  end else begin
                     mem_en_q <= 1'b1;
                     w_en_q   <= in_store;
                     state_q  <= LSU_ACCESS;
                  end
               end
            end
            LSU_ACCESS: begin
               w_en_q <= 1'b0;
               if (cnt_q == CNT_LAST) begin
                  mem_en_q    <= 1'b0;
                  rdata_q     <= load_q ? ext_data : 64'd0;
                  skip_q      <= mem_skip_ref;
                  rf_wen_q    <= load_q && (rd_q != 5'd0);
                  out_valid_q <= 1'b1;
                  state_q     <= LSU_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            LSU_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= LSU_IDLE;
               end
            end
            default: state_q <= LSU_IDLE;
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign mem_en       = mem_en_q;
   assign mem_r_addr   = addr_q;
   assign mem_w_en     = w_en_q;
   assign mem_w_addr   = addr_q;
   assign mem_w_data   = wdata_q;
   assign mem_w_width  = width_q;
   assign out_valid    = out_valid_q;
   assign out_rdata    = rdata_q;
   assign out_rd       = rd_q;
   assign out_rf_wen   = rf_wen_q;
   assign out_skip_ref = skip_q;
   assign out_misalign = misalign_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed bench for lsu_ctrl at MEM_LAT=1 and MEM_LAT=3
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_valid3, out_ready, out_ready3;
   logic        in_load, in_store, mem_skip_ref;
   logic [2:0]  in_funct3;
   logic [63:0] in_addr, in_wdata, mem_r_data;
   logic [4:0]  in_rd;

   logic        in_ready, mem_en, mem_w_en, out_valid, out_rf_wen, out_skip_ref, out_misalign;
   logic [63:0] mem_r_addr, mem_w_addr, mem_w_data, out_rdata;
   logic [3:0]  mem_w_width;
   logic [4:0]  out_rd;

   logic        in_ready3, mem_en3, mem_w_en3, out_valid3, out_rf_wen3, out_skip_ref3, out_misalign3;
   logic [63:0] mem_r_addr3, mem_w_addr3, mem_w_data3, out_rdata3;
   logic [3:0]  mem_w_width3;
   logic [4:0]  out_rd3;

   int n_assert = 0;
   int n_fail   = 0;
   int cnt_en, cnt_w;

   always #5 clk = ~clk;

   lsu_ctrl #(.MEM_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_rd(in_rd), .mem_en(mem_en), .mem_r_addr(mem_r_addr),
      .mem_r_data(mem_r_data), .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr),
      .mem_w_data(mem_w_data), .mem_w_width(mem_w_width), .mem_skip_ref(mem_skip_ref),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
      .out_rf_wen(out_rf_wen), .out_skip_ref(out_skip_ref), .out_misalign(out_misalign)
   );

   lsu_ctrl #(.MEM_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_rd(in_rd), .mem_en(mem_en3), .mem_r_addr(mem_r_addr3),
      .mem_r_data(mem_r_data), .mem_w_en(mem_w_en3), .mem_w_addr(mem_w_addr3),
      .mem_w_data(mem_w_data3), .mem_w_width(mem_w_width3), .mem_skip_ref(mem_skip_ref),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_rdata(out_rdata3), .out_rd(out_rd3),
      .out_rf_wen(out_rf_wen3), .out_skip_ref(out_skip_ref3), .out_misalign(out_misalign3)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Drives a request for one cycle; returns at the negedge after the accepting posedge.
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] rdat, input logic skip);
      in_load = ld; in_store = st; in_funct3 = f3; in_addr = addr;
      in_wdata = wd; in_rd = rd; mem_r_data = rdat; mem_skip_ref = skip;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
      check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0; out_ready = 1'b0; out_ready3 = 1'b0;
      in_load = 1'b0; in_store = 1'b0; in_funct3 = 3'd0; in_addr = '0; in_wdata = '0;
      in_rd = '0; mem_r_data = '0; mem_skip_ref = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_mem_en", {63'd0, mem_en}, 64'd0);
      check("rst_w_en", {63'd0, mem_w_en}, 64'd0);
      check("rst_w_width", {60'd0, mem_w_width}, 64'd0);
      check("rst_rdata", out_rdata, 64'd0);
      rst_n = 1'b1;

      // LB with negative byte
      issue(1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'd0, 5'd5, 64'h1122_3344_5566_7780, 1'b0);
      check("lb_mem_en", {63'd0, mem_en}, 64'd1);
      check("lb_r_addr", mem_r_addr, 64'h8000_0003);
      check("lb_w_en", {63'd0, mem_w_en}, 64'd0);
      check("lb_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      check("lb_valid", {63'd0, out_valid}, 64'd1);
      check("lb_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      check("lb_rf_wen", {63'd0, out_rf_wen}, 64'd1);
      check("lb_rd", {59'd0, out_rd}, 64'd5);
      check("lb_mem_en_off", {63'd0, mem_en}, 64'd0);
      handshake("lb");

      // LWU to rd=0: zero-extended data but no register write
      issue(1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'd0, 5'd0, 64'h0000_0000_8765_4321, 1'b0);
      @(negedge clk);
      check("lwu_rdata", out_rdata, 64'h0000_0000_8765_4321);
      check("lwu_rf_wen", {63'd0, out_rf_wen}, 64'd0);
      handshake("lwu");

      issue(1'b1, 1'b0, 3'b001, 64'h8000_0006, 64'd0, 5'd7, 64'h1234_5678_9ABC_8765, 1'b0);
      @(negedge clk);
      check("lh_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_8765);
      handshake("lh");

      // SH, then hold out_ready low for 5 cycles
      issue(1'b0, 1'b1, 3'b001, 64'h8000_0010, 64'h0000_0000_0000_BEEF, 5'd9, 64'd0, 1'b0);
      check("sh_w_en", {63'd0, mem_w_en}, 64'd1);
      check("sh_w_width", {60'd0, mem_w_width}, 64'd2);
      check("sh_w_addr", mem_w_addr, 64'h8000_0010);
      check("sh_w_data", mem_w_data, 64'h0000_0000_0000_BEEF);
      @(negedge clk);
      check("sh_w_en_off", {63'd0, mem_w_en}, 64'd0);
      check("sh_rdata", out_rdata, 64'd0);
      check("sh_rf_wen", {63'd0, out_rf_wen}, 64'd0);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_in_ready", {63'd0, in_ready}, 64'd0);
         check("hold_w_width", {60'd0, mem_w_width}, 64'd2);
         @(negedge clk);
      end
      handshake("sh");

      // Misaligned LW with skip_ref asserted: no access, skip forced 0
      issue(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 5'd3, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
      check("mis_valid", {63'd0, out_valid}, 64'd1);
      check("mis_flag", {63'd0, out_misalign}, 64'd1);
      check("mis_mem_en", {63'd0, mem_en}, 64'd0);
      check("mis_rdata", out_rdata, 64'd0);
      check("mis_skip", {63'd0, out_skip_ref}, 64'd0);
      check("mis_rf_wen", {63'd0, out_rf_wen}, 64'd0);
      handshake("mis");

      issue(1'b0, 1'b0, 3'b000, 64'h8000_0000, 64'd0, 5'd1, 64'd0, 1'b0);
      check("nop_in_ready", {63'd0, in_ready}, 64'd1);
      check("nop_mem_en", {63'd0, mem_en}, 64'd0);
      check("nop_valid", {63'd0, out_valid}, 64'd0);

      // LD to a device region
      issue(1'b1, 1'b0, 3'b011, 64'hA000_0048, 64'd0, 5'd4, 64'h0123_4567_89AB_CDEF, 1'b1);
      @(negedge clk);
      check("dev_skip", {63'd0, out_skip_ref}, 64'd1);
      check("dev_rdata", out_rdata, 64'h0123_4567_89AB_CDEF);
      check("dev_misalign", {63'd0, out_misalign}, 64'd0);
      handshake("dev");

      // Reset while a store is in ACCESS
      issue(1'b0, 1'b1, 3'b011, 64'h8000_0020, 64'h55AA_55AA_55AA_55AA, 5'd2, 64'd0, 1'b0);
      check("rma_w_en_pre", {63'd0, mem_w_en}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("rma_w_en", {63'd0, mem_w_en}, 64'd0);
      check("rma_mem_en", {63'd0, mem_en}, 64'd0);
      check("rma_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rma_valid", {63'd0, out_valid}, 64'd0);
      check("rma_in_ready2", {63'd0, in_ready}, 64'd1);

      // MEM_LAT=3 instance: SW holds mem_en 3 cycles, w_en only the first
      in_load = 1'b0; in_store = 1'b1; in_funct3 = 3'b010; in_addr = 64'h8000_0030;
      in_wdata = 64'h0000_0000_CAFE_F00D; mem_skip_ref = 1'b0;
      in_valid3 = 1'b1;
      @(negedge clk);
      in_valid3 = 1'b0;
      cnt_en = 0;
      cnt_w  = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid3) break;
         cnt_en += int'(mem_en3);
         cnt_w  += int'(mem_w_en3);
         @(negedge clk);
      end
      check("lat3_valid", {63'd0, out_valid3}, 64'd1);
      check("lat3_en_cycles", 64'(cnt_en), 64'd3);
      check("lat3_w_cycles", 64'(cnt_w), 64'd1);
      check("lat3_w_width", {60'd0, mem_w_width3}, 64'd4);
      out_ready3 = 1'b1;
      @(negedge clk);
      out_ready3 = 1'b0;
      check("lat3_in_ready", {63'd0, in_ready3}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
